// File: rtl/sr_cmd_pkg.sv
// Shared types and defaults for the debounced set/clear command generator.
package sr_cmd_pkg;

   localparam int unsigned SR_CMD_DEBOUNCE_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMING    = 2'd1,
      PRESSED   = 2'd2,
      RELEASING = 2'd3
   } db_state_e;

endpackage

// File: rtl/sr_debounce.sv
// One button channel: optional 2-flop synchronizer (SR_CMD_GEN_SYNC_EN),
// press/release debounce FSM, and a registered single-cycle hit per press.
module sr_debounce
   import sr_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = SR_CMD_DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic hit
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic smp;

`ifdef SR_CMD_GEN_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[0], btn};
   end

   assign smp = sync_q[1];
`else
   assign smp = btn;
`endif

   db_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          hit_d;

   assign cnt_inc = cnt_q + CNT_ONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hit     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hit     <= hit_d;
      end
   end

   // The first qualifying sample counts as 1, so DEBOUNCE_CYCLES=1 completes immediately.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hit_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (smp) begin
               if (CNT_ONE == CNT_DONE) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
                  hit_d   = 1'b1;
               end else begin
                  state_d = ARMING;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         ARMING: begin
            if (!smp) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_inc == CNT_DONE) begin
               state_d = PRESSED;
               cnt_d   = '0;
               hit_d   = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         PRESSED: begin
            if (!smp) begin
               if (CNT_ONE == CNT_DONE) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d = RELEASING;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         RELEASING: begin
            if (smp) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_inc == CNT_DONE) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/sr_cmd_gen.sv
// Debounced set/clear command generator for an SR stage; s and r are never both high.
// Build with SR_CMD_GEN_SYNC_EN defined to synchronize the raw button inputs.
module sr_cmd_gen
   import sr_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = SR_CMD_DEBOUNCE_DEFAULT,
   parameter int unsigned RST_PRIORITY    = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic set_btn,
   input  logic clr_btn,
   output logic s,
   output logic r,
   output logic conflict
);

   localparam logic R_WINS = (RST_PRIORITY != 0);

   logic set_hit, clr_hit;
   logic s_d, r_d, conflict_d;

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
      .clk (clk),
      .rst (rst),
      .btn (set_btn),
      .hit (set_hit)
   );

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
      .clk (clk),
      .rst (rst),
      .btn (clr_btn),
      .hit (clr_hit)
   );

   // On a tie only the priority winner fires; the loser is dropped, not queued.
   always_comb begin
      s_d        = set_hit & ~(clr_hit &  R_WINS);
      r_d        = clr_hit & ~(set_hit & ~R_WINS);
      conflict_d = set_hit & clr_hit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s        <= 1'b0;
         r        <= 1'b0;
         conflict <= 1'b0;
      end else begin
         s        <= s_d;
         r        <= r_d;
         conflict <= conflict_d;
      end
   end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen: two instances differing only in RST_PRIORITY.
module tb_sr_cmd_gen;
   import sr_cmd_pkg::*;

   localparam int unsigned D = 4;
`ifdef SR_CMD_GEN_SYNC_EN
   localparam int LAT = D + 3;
`else
   localparam int LAT = D + 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic set_btn = 1'b0;
   logic clr_btn = 1'b0;
   logic s1, r1, c1, s0, r0, c0;
   logic [2:0] o1, o0;
   int checks = 0;
   int errors = 0;

   assign o1 = {s1, r1, c1};
   assign o0 = {s0, r0, c0};

   always #5 clk = ~clk;

   sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .RST_PRIORITY(1)) dut1 (
      .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
      .s(s1), .r(r1), .conflict(c1)
   );

   sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .RST_PRIORITY(0)) dut0 (
      .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
      .s(s0), .r(r0), .conflict(c0)
   );

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic quiet(input string tag, input int n);
      repeat (n) begin
         tick(1);
         chk(tag, o1, 3'b000);
         chk(tag, o0, 3'b000);
      end
   endtask

   task automatic pulse(input string tag, input logic [2:0] e1, input logic [2:0] e0);
      tick(1);
      chk({tag, "_p1"}, o1, e1);
      chk({tag, "_p0"}, o0, e0);
   endtask

   // s and r must never be high together on either instance
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         assert (!(s1 && r1) && !(s0 && r0))
         else begin
            errors++;
            $error("FAIL sr_both observed=%b%b%b%b expected=no_11", s1, r1, s0, r0);
         end
      end
   end

   initial begin
      // reset held with set button high: nothing may fire
      set_btn = 1'b1;
      #2 rst = 1'b1;
      tick(1);
      quiet("rst_hold", 3);
      rst = 1'b0;
      quiet("rst_requal", LAT - 1);
      pulse("rst_pulse", 3'b100, 3'b100);
      quiet("rst_held", 10);
      set_btn = 1'b0;
      quiet("rst_release", 10);

      // clean press, single pulse while held
      set_btn = 1'b1;
      quiet("clean_pre", LAT - 1);
      pulse("clean", 3'b100, 3'b100);
      quiet("clean_held", 6);
      set_btn = 1'b0;
      quiet("clean_rel", 10);

      // bounce 1,1,0 then a steady run
      set_btn = 1'b1;
      quiet("bounce_a", 2);
      set_btn = 1'b0;
      quiet("bounce_b", 1);
      set_btn = 1'b1;
      quiet("bounce_pre", LAT - 1);
      pulse("bounce", 3'b100, 3'b100);
      quiet("bounce_held", 4);
      set_btn = 1'b0;
      quiet("bounce_rel", 10);

      // simultaneous press: priority decides, conflict flagged
      set_btn = 1'b1;
      clr_btn = 1'b1;
      quiet("simul_pre", LAT - 1);
      pulse("simul", 3'b011, 3'b101);
      quiet("simul_held", 5);
      set_btn = 1'b0;
      clr_btn = 1'b0;
      quiet("simul_rel", 10);

      // clear channel: short release must not re-arm, full release must
      clr_btn = 1'b1;
      quiet("clr_pre", LAT - 1);
      pulse("clr", 3'b010, 3'b010);
      quiet("clr_held", 3);
      clr_btn = 1'b0;
      quiet("short_rel", 3);
      clr_btn = 1'b1;
      quiet("short_repress", LAT + 6);
      clr_btn = 1'b0;
      quiet("full_rel", 4);
      clr_btn = 1'b1;
      quiet("repress_pre", LAT - 1);
      pulse("repress", 3'b010, 3'b010);
      quiet("repress_held", 3);
      clr_btn = 1'b0;
      quiet("repress_rel", 10);

      // reset while arming at count 3
      set_btn = 1'b1;
      quiet("arm_pre", LAT - 2);
      chk("arm_state", {1'b0, 2'(dut1.u_set_db.state_q)}, {1'b0, 2'(ARMING)});
      rst = 1'b1;
      #1;
      chk("rst_async_state", {1'b0, 2'(dut1.u_set_db.state_q)}, {1'b0, 2'(IDLE)});
      chk("rst_async_out1", o1, 3'b000);
      chk("rst_async_out0", o0, 3'b000);
      quiet("mid_rst_hold", 2);
      rst = 1'b0;
      quiet("mid_requal", LAT - 1);
      pulse("mid_pulse", 3'b100, 3'b100);
      quiet("mid_held", 3);
      set_btn = 1'b0;
      quiet("mid_rel", 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
